// File: rtl/exception_controller.sv
// exception_controller
// Consumes the exception flag and raw cause bits from the detect stage.
// On an exception it saves the faulting PC, latches a priority-encoded cause,
// squashes the pipeline for FLUSH_CYCLES cycles and redirects fetch to the
// handler vector. It tracks handler residency and returns fetch to the saved
// PC when the handler requests an exception return.
module exception_controller #(
  parameter int                  PC_WIDTH       = 32,
  parameter logic [PC_WIDTH-1:0] HANDLER_VECTOR = 32'h0000_0080,
  parameter int                  FLUSH_CYCLES   = 2
) (
  input  logic                EC_clk,
  input  logic                EC_reset,
  input  logic                EC_flag,
  input  logic                EC_overflow,
  input  logic                EC_invalid_addr,
  input  logic                EC_div_zero,
  input  logic                EC_control,
  input  logic                EC_write2_0,
  input  logic [PC_WIDTH-1:0] EC_pc,
  input  logic                EC_eret,
  input  logic                EC_clr_df,
  output logic                EC_flush,
  output logic                EC_pc_sel,
  output logic [PC_WIDTH-1:0] EC_pc_target,
  output logic [PC_WIDTH-1:0] EC_epc,
  output logic [2:0]          EC_cause,
  output logic                EC_in_handler,
  output logic                EC_double_fault
);

  // Controller states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FLUSH    = 3'd1;
  localparam logic [2:0] ST_REDIRECT = 3'd2;
  localparam logic [2:0] ST_HANDLER  = 3'd3;
  localparam logic [2:0] ST_RETURN   = 3'd4;

  // The flush length fits in four bits (1..15).
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  // Cause codes
  localparam logic [2:0] CAUSE_UNKNOWN = 3'd7;
  localparam int         NUM_CAUSES    = 5;

  logic [2:0]          state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                flush_reg, flush_next;
  logic                pc_sel_reg, pc_sel_next;
  logic [PC_WIDTH-1:0] pc_target_reg, pc_target_next;
  logic [PC_WIDTH-1:0] epc_reg, epc_next;
  logic [2:0]          cause_reg, cause_next;
  logic                in_handler_reg, in_handler_next;
  logic                double_fault_reg, double_fault_next;

  // ---------------------------------------------------------------------
  // Cause priority encoder. Bit 0 is the highest priority and maps to
  // code 1, bit 4 maps to code 5. A flag with no cause bit is "unknown".
  // ---------------------------------------------------------------------
  logic [NUM_CAUSES-1:0] cause_bits;
  logic [NUM_CAUSES-1:0] first_hit;
  logic [2:0]            hit_code [NUM_CAUSES];
  logic [2:0]            enc_cause;

  assign cause_bits = {EC_write2_0, EC_control, EC_div_zero, EC_overflow, EC_invalid_addr};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CAUSES; gi++) begin : g_prio
      if (gi == 0) begin : g_top
        assign first_hit[gi] = cause_bits[gi];
      end else begin : g_rest
        // A lower-priority bit only wins if nothing above it is set.
        assign first_hit[gi] = cause_bits[gi] & ~(|cause_bits[gi-1:0]);
      end
      assign hit_code[gi] = first_hit[gi] ? 3'(gi + 1) : 3'd0;
    end
  endgenerate

  // Merge the one-hot winner's code; fall back to "unknown" with no cause.
  always_comb begin
    enc_cause = 3'd0;
    for (int i = 0; i < NUM_CAUSES; i++) begin
      enc_cause = enc_cause | hit_code[i];
    end
    if (cause_bits == '0) begin
      enc_cause = CAUSE_UNKNOWN;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and next-output logic. Every output is registered, so the
  // combinational block computes the value each register takes next edge.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    flush_next        = flush_reg;
    pc_sel_next       = pc_sel_reg;
    pc_target_next    = pc_target_reg;
    epc_next          = epc_reg;
    cause_next        = cause_reg;
    in_handler_next   = in_handler_reg;
    double_fault_next = double_fault_reg;

    // Clearing the sticky bit is allowed in any state; a double fault
    // raised in the same cycle overrides it below.
    if (EC_clr_df) begin
      double_fault_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        // Exception return with nothing to return from is ignored.
        if (EC_flag) begin
          epc_next   = EC_pc;
          cause_next = enc_cause;
          cnt_next   = FLUSH_INIT;
          flush_next = 1'b1;
          state_next = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        // The count loaded on entry covers the first flush cycle, so the
        // redirect is issued on the edge where the last count remains.
        if (cnt_reg <= 4'd1) begin
          cnt_next       = 4'd0;
          flush_next     = 1'b0;
          pc_sel_next    = 1'b1;
          pc_target_next = HANDLER_VECTOR;
          state_next     = ST_REDIRECT;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      ST_REDIRECT: begin
        pc_sel_next     = 1'b0;
        in_handler_next = 1'b1;
        state_next      = ST_HANDLER;
      end

      ST_HANDLER: begin
        // A fault inside the handler is only recorded; the saved context
        // is kept so the original exception can still be returned from.
        if (EC_flag) begin
          double_fault_next = 1'b1;
        end else if (EC_eret) begin
          pc_sel_next     = 1'b1;
          pc_target_next  = epc_reg;
          in_handler_next = 1'b0;
          state_next      = ST_RETURN;
        end
      end

      ST_RETURN: begin
        pc_sel_next = 1'b0;
        state_next  = ST_IDLE;
      end

      default: begin
        state_next      = ST_IDLE;
        cnt_next        = 4'd0;
        flush_next      = 1'b0;
        pc_sel_next     = 1'b0;
        in_handler_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in progress.
  always_ff @(posedge EC_clk or posedge EC_reset) begin
    if (EC_reset) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= 4'd0;
      flush_reg        <= 1'b0;
      pc_sel_reg       <= 1'b0;
      pc_target_reg    <= '0;
      epc_reg          <= '0;
      cause_reg        <= 3'd0;
      in_handler_reg   <= 1'b0;
      double_fault_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      flush_reg        <= flush_next;
      pc_sel_reg       <= pc_sel_next;
      pc_target_reg    <= pc_target_next;
      epc_reg          <= epc_next;
      cause_reg        <= cause_next;
      in_handler_reg   <= in_handler_next;
      double_fault_reg <= double_fault_next;
    end
  end

  assign EC_flush        = flush_reg;
  assign EC_pc_sel       = pc_sel_reg;
  assign EC_pc_target    = pc_target_reg;
  assign EC_epc          = epc_reg;
  assign EC_cause        = cause_reg;
  assign EC_in_handler   = in_handler_reg;
  assign EC_double_fault = double_fault_reg;

endmodule

// File: tb/tb_exception_controller.sv
// Bench for exception_controller: directed scenarios followed by random
// stimulus, all checked each cycle against a timestamp-based reference model.
module tb_exception_controller;

  localparam int          F  = 2;
  localparam logic [31:0] HV = 32'h0000_0080;

  logic        clk;
  logic        rst;
  logic        flag, ovf, inv, dz, ctl, w20;
  logic [31:0] pc;
  logic        eret, clr_df;
  logic        flush, pc_sel, in_handler, double_fault;
  logic [31:0] pc_target, epc;
  logic [2:0]  cause;

  exception_controller #(
    .PC_WIDTH(32),
    .HANDLER_VECTOR(HV),
    .FLUSH_CYCLES(F)
  ) dut (
    .EC_clk(clk),
    .EC_reset(rst),
    .EC_flag(flag),
    .EC_overflow(ovf),
    .EC_invalid_addr(inv),
    .EC_div_zero(dz),
    .EC_control(ctl),
    .EC_write2_0(w20),
    .EC_pc(pc),
    .EC_eret(eret),
    .EC_clr_df(clr_df),
    .EC_flush(flush),
    .EC_pc_sel(pc_sel),
    .EC_pc_target(pc_target),
    .EC_epc(epc),
    .EC_cause(cause),
    .EC_in_handler(in_handler),
    .EC_double_fault(double_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an exception is described by the edge on which it was
  // accepted and the edge on which the handler returned; every output is
  // derived from those timestamps.
  int          edge_k = 0;
  bit          m_active, m_returned, m_df;
  int          m_exc, m_ret;
  logic [31:0] m_epc, m_target;
  logic [2:0]  m_cause;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edge_k);
    end
  endtask

  function automatic logic [2:0] prio_cause(input logic a_inv, a_ovf, a_dz, a_ctl, a_w20);
    if (a_inv)      return 3'd1;
    else if (a_ovf) return 3'd2;
    else if (a_dz)  return 3'd3;
    else if (a_ctl) return 3'd4;
    else if (a_w20) return 3'd5;
    else            return 3'd7;
  endfunction

  task automatic model_reset();
    m_active = 0; m_returned = 0; m_df = 0;
    m_exc = 0; m_ret = 0;
    m_epc = '0; m_target = '0; m_cause = '0;
  endtask

  task automatic model_edge();
    bit idle, set_df;
    idle   = !m_active || (m_returned && edge_k >= m_ret + 2);
    set_df = 0;
    if (idle) begin
      if (flag) begin
        m_active = 1; m_returned = 0; m_exc = edge_k;
        m_epc = pc; m_cause = prio_cause(inv, ovf, dz, ctl, w20);
        $display("edge %0d: exception pc=%h cause=%0d", edge_k, pc, m_cause);
      end
    end else if (!m_returned && edge_k >= m_exc + F + 2) begin
      if (flag) begin
        m_df = 1; set_df = 1;
      end else if (eret) begin
        m_returned = 1; m_ret = edge_k; m_target = m_epc;
        $display("edge %0d: return to %h", edge_k, m_epc);
      end
    end
    if (m_active && !m_returned && edge_k == m_exc + F) m_target = HV;
    if (clr_df && !set_df) m_df = 0;
  endtask

  task automatic compare_all();
    bit e_flush, e_sel, e_inh;
    e_flush = m_active && !m_returned && (edge_k - m_exc) < F;
    e_sel   = m_active && ((!m_returned && edge_k == m_exc + F) ||
                           (m_returned && edge_k == m_ret));
    e_inh   = m_active && !m_returned && edge_k >= m_exc + F + 1;
    check("flush", 32'(flush), 32'(e_flush));
    check("pc_sel", 32'(pc_sel), 32'(e_sel));
    check("in_handler", 32'(in_handler), 32'(e_inh));
    check("double_fault", 32'(double_fault), 32'(m_df));
    check("epc", epc, m_epc);
    check("cause", 32'(cause), 32'(m_cause));
    check("pc_target", pc_target, m_target);
  endtask

  task automatic drive(input logic f, input logic [4:0] c, input logic [31:0] p,
                       input logic e, input logic cl);
    flag = f; {w20, ctl, dz, ovf, inv} = c; pc = p; eret = e; clr_df = cl;
  endtask

  task automatic step();
    @(posedge clk);
    edge_k++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 5'b0, 32'h0, 0, 0);
      step();
    end
  endtask

  // cause vector order: {write2_0, control, div_zero, overflow, invalid_addr}
  initial begin
    rst = 1'b1;
    drive(0, 5'b0, 32'h0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Divide-by-zero at PC 0x40; flags during FLUSH/REDIRECT are ignored.
    drive(1, 5'b00100, 32'h40, 0, 0); step();
    drive(1, 5'b00001, 32'h1234, 0, 0); step();
    drive(1, 5'b00010, 32'h5678, 0, 0); step();
    check("dp_redirect_sel", 32'(pc_sel), 32'd1);
    check("dp_redirect_tgt", pc_target, 32'h80);
    drive(1, 5'b10000, 32'h9abc, 0, 0); step();
    idle_steps(2);
    check("dp_epc", epc, 32'h40);
    check("dp_cause", 32'(cause), 32'd3);
    check("dp_in_handler", 32'(in_handler), 32'd1);

    // Exception return to the saved PC.
    drive(0, 5'b0, 32'h0, 1, 0); step();
    check("eret_sel", 32'(pc_sel), 32'd1);
    check("eret_tgt", pc_target, 32'h40);
    idle_steps(2);

    // Return request in IDLE does nothing.
    drive(0, 5'b0, 32'h0, 1, 0); step();
    check("idle_eret_sel", 32'(pc_sel), 32'd0);
    idle_steps(1);

    // Invalid address beats overflow; then flag+eret in the handler.
    drive(1, 5'b00011, 32'h100, 0, 0); step();
    idle_steps(4);
    check("prio_cause", 32'(cause), 32'd1);
    drive(1, 5'b01000, 32'h200, 1, 0); step();
    check("df_set", 32'(double_fault), 32'd1);
    check("df_epc", epc, 32'h100);
    idle_steps(2);
    drive(0, 5'b0, 32'h0, 0, 1); step();
    check("df_clr", 32'(double_fault), 32'd0);

    // Return, then an unknown-cause exception right after RETURN.
    drive(0, 5'b0, 32'h0, 1, 0); step();
    idle_steps(1);
    drive(1, 5'b00000, 32'h300, 0, 0); step();
    check("b2b_flush", 32'(flush), 32'd1);
    check("unknown_cause", 32'(cause), 32'd7);
    idle_steps(4);

    // Reset mid-FLUSH: outputs clear immediately, no redirect follows.
    drive(0, 5'b0, 32'h0, 1, 0); step();
    idle_steps(1);
    drive(1, 5'b00100, 32'h400, 0, 0); step();
    idle_steps(1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    idle_steps(F + 3);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] c;
      c = 5'($urandom);
      if ($urandom_range(0, 3) == 0) c = 5'b0;
      drive(($urandom_range(0, 5) == 0), c, $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exception_controller.md
Name: exception_controller

Overview:
- Sequential consumer of the exception flag and the raw cause bits from the exception-detect stage.
- On an exception it:
  - captures the faulting PC into EPC;
  - priority-encodes and latches the cause;
  - flushes the pipeline for a fixed number of cycles;
  - redirects fetch to the handler vector.
- Tracks handler residency and returns fetch to EPC on an exception-return request.
- Sits between exception detection and the PC-select / pipeline-flush logic.

Parameters:
- PC_WIDTH, 32, width of PC, EPC and redirect target.
- HANDLER_VECTOR, 32'h0000_0080, fetch address of the exception handler.
- FLUSH_CYCLES, 2, number of cycles EC_flush is held (legal range 1..15).

Ports:
- EC_clk  input  1  system clock, rising edge.
- EC_reset  input  1  asynchronous, active-high reset.
- EC_flag  input  1  aggregate exception flag from the detect stage.
- EC_overflow  input  1  arithmetic overflow cause.
- EC_invalid_addr  input  1  invalid memory address cause.
- EC_div_zero  input  1  divide-by-zero cause.
- EC_control  input  1  illegal control / opcode cause.
- EC_write2_0  input  1  write-to-$0 cause.
- EC_pc  input  PC_WIDTH  PC of the instruction raising the exception.
- EC_eret  input  1  exception-return request from the handler.
- EC_clr_df  input  1  clear the sticky double-fault bit.
- EC_flush  output  1  pipeline flush / squash.
- EC_pc_sel  output  1  redirect fetch to EC_pc_target this cycle.
- EC_pc_target  output  PC_WIDTH  redirect address.
- EC_epc  output  PC_WIDTH  saved exception PC.
- EC_cause  output  3  latched cause code.
- EC_in_handler  output  1  handler executing.
- EC_double_fault  output  1  sticky: exception raised while in handler.

Behaviour:
- All outputs are registered. EC_reset asserted at any time forces, immediately:
  - state IDLE, flush counter 0;
  - EC_flush=0, EC_pc_sel=0, EC_pc_target=0, EC_epc=0, EC_cause=0, EC_in_handler=0, EC_double_fault=0.
- Reset mid-flush or mid-handler abandons the operation; no redirect is issued.
- Cause encoding, highest priority first:
  - invalid_addr = 3'd1
  - overflow = 3'd2
  - div_zero = 3'd3
  - control = 3'd4
  - write2_0 = 3'd5
  - EC_flag high with no cause bit set = 3'd7 (unknown)
  - 3'd0 = none
- Cause bits are sampled only when EC_flag=1.
- States: IDLE, FLUSH, REDIRECT, HANDLER, RETURN.
- IDLE:
  - On an edge with EC_flag=1: EC_epc<=EC_pc, EC_cause<=encoded cause, counter<=FLUSH_CYCLES, EC_flush<=1, go to FLUSH.
  - EC_eret in IDLE is ignored.
- FLUSH:
  - Counter decrements each cycle; EC_flush stays 1 for exactly FLUSH_CYCLES cycles.
  - When the count expires: EC_flush<=0, EC_pc_sel<=1, EC_pc_target<=HANDLER_VECTOR, go to REDIRECT.
- REDIRECT: one cycle. EC_pc_sel<=0, EC_in_handler<=1, go to HANDLER.
- HANDLER:
  - EC_flag=1: EC_double_fault<=1; EPC, cause and state are unchanged.
  - Otherwise, EC_eret=1: EC_pc_sel<=1, EC_pc_target<=EC_epc, EC_in_handler<=0, go to RETURN.
  - EC_flag and EC_eret in the same cycle: the flag wins and EC_eret is dropped.
- RETURN: one cycle. EC_pc_sel<=0, go to IDLE. EC_cause retains its last value until the next exception.
- EC_flag is ignored in FLUSH, REDIRECT and RETURN; the pipeline is being squashed.
- EC_clr_df=1 clears EC_double_fault next edge. If EC_clr_df and a new double fault occur in the same cycle, the set wins.
- Latency, with flag sampled at edge N:
  - EC_flush high for cycles N+1 .. N+FLUSH_CYCLES;
  - EC_pc_sel high for one cycle at N+FLUSH_CYCLES+1;
  - EC_in_handler high from N+FLUSH_CYCLES+2.
- A back-to-back exception arriving in IDLE on the cycle after RETURN is accepted normally.

Test Plan:
- Reset, then EC_flag=1, EC_div_zero=1, EC_pc=32'h0000_0040 -> EC_epc=32'h40, EC_cause=3, EC_flush high 2 cycles, then EC_pc_sel=1 with target 32'h80 for 1 cycle, then EC_in_handler=1.
- EC_flag with EC_overflow=1 and EC_invalid_addr=1 -> EC_cause=1; EC_flag alone with no cause bit -> EC_cause=7.
- In HANDLER, EC_eret=1 -> EC_pc_sel=1, target=EC_epc (32'h40) for one cycle; EC_in_handler=0; state returns to IDLE.
- In HANDLER, EC_flag=1 and EC_eret=1 in the same cycle -> EC_double_fault=1, EPC and cause unchanged, no redirect. A later EC_clr_df=1 -> EC_double_fault=0.
- EC_reset asserted mid-FLUSH -> all outputs 0 immediately (asynchronous); no EC_pc_sel pulse follows.
- EC_flag pulses during FLUSH/REDIRECT are ignored: EPC is unchanged. EC_eret in IDLE produces no redirect.
